// File: rtl/pipe_hazard_sb.sv
// ID-stage hazard/forwarding unit with a one-entry scoreboard for a fixed-latency multi-cycle unit.
// Define PIPE_WB_FWD_EN to add the WB bypass ports (wwreg, wrn, wdi) and forward select 100.
`timescale 1ns/1ps

module pipe_hazard_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RAW    = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             d_valid,
  input  logic [RAW-1:0]   rs,
  input  logic [RAW-1:0]   rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             d_wreg,
  input  logic [RAW-1:0]   d_rn,
  input  logic             d_mc,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [RAW-1:0]   ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [RAW-1:0]   mrn,
  input  logic [XLEN-1:0]  qa,
  input  logic [XLEN-1:0]  qb,
  input  logic [XLEN-1:0]  ealu,
  input  logic [XLEN-1:0]  malu,
  input  logic [XLEN-1:0]  mmo,
`ifdef PIPE_WB_FWD_EN
  input  logic             wwreg,
  input  logic [RAW-1:0]   wrn,
  input  logic [XLEN-1:0]  wdi,
`endif
  output logic [2:0]       fwda,
  output logic [2:0]       fwdb,
  output logic [XLEN-1:0]  da,
  output logic [XLEN-1:0]  db,
  output logic             wpcir,
  output logic             dbubble,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MCW = (MC_LAT < 1) ? 1 : $clog2(MC_LAT + 1);
  localparam logic [MCW-1:0] McLatV = MCW'(MC_LAT);

  logic [MCW-1:0]   r_mc_cnt;
  logic [RAW-1:0]   r_mc_rn;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [MCW-1:0]   w_mc_cnt_nxt;
  logic [RAW-1:0]   w_mc_rn_nxt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;

  logic             w_wwreg;
  logic [RAW-1:0]   w_wrn;
  logic [XLEN-1:0]  w_wdi;

  logic w_mc_busy, w_load_use, w_mc_raw, w_mc_waw, w_struct, w_stall;

`ifdef PIPE_WB_FWD_EN
  assign w_wwreg = wwreg;
  assign w_wrn   = wrn;
  assign w_wdi   = wdi;
`else
  // WB path tied off so select 100 can never be produced.
  assign w_wwreg = 1'b0;
  assign w_wrn   = '0;
  assign w_wdi   = '0;
`endif

  function automatic logic [2:0] fwd_sel(input logic [RAW-1:0] src,
                                         input logic e_wr, input logic e_ld,
                                         input logic [RAW-1:0] e_rn,
                                         input logic m_wr, input logic m_ld,
                                         input logic [RAW-1:0] m_rn,
                                         input logic w_wr, input logic [RAW-1:0] w_rn);
    logic [2:0] sel;
    sel = 3'b000;
    if (src == '0)                         sel = 3'b000;
    else if (e_wr && !e_ld && e_rn == src) sel = 3'b001;
    else if (m_wr && m_rn == src)          sel = m_ld ? 3'b011 : 3'b010;
    else if (w_wr && w_rn == src)          sel = 3'b100;
    return sel;
  endfunction

  function automatic logic [XLEN-1:0] fwd_mux(input logic [2:0] sel, input logic [XLEN-1:0] q,
                                              input logic [XLEN-1:0] e, input logic [XLEN-1:0] m,
                                              input logic [XLEN-1:0] mo,
                                              input logic [XLEN-1:0] w);
    logic [XLEN-1:0] res;
    case (sel)
      3'b001:  res = e;
      3'b010:  res = m;
      3'b011:  res = mo;
      3'b100:  res = w;
      default: res = q;
    endcase
    return res;
  endfunction

  always_comb begin
    fwda = fwd_sel(rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn, w_wwreg, w_wrn);
    fwdb = fwd_sel(rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn, w_wwreg, w_wrn);
    da   = fwd_mux(fwda, qa, ealu, malu, mmo, w_wdi);
    db   = fwd_mux(fwdb, qb, ealu, malu, mmo, w_wdi);
  end

  always_comb begin
    w_mc_busy  = (r_mc_cnt != '0);
    w_load_use = ewreg && em2reg && (ern != '0) &&
                 ((use_rs && ern == rs) || (use_rt && ern == rt));
    // No MC bypass exists: dependants wait until the result has reached the regfile.
    w_mc_raw   = w_mc_busy && (r_mc_rn != '0) &&
                 ((use_rs && r_mc_rn == rs) || (use_rt && r_mc_rn == rt));
    w_mc_waw   = w_mc_busy && d_wreg && (d_rn == r_mc_rn) && (r_mc_rn != '0);
    w_struct   = w_mc_busy && d_mc;
    w_stall    = d_valid && (w_load_use || w_mc_raw || w_mc_waw || w_struct);
    wpcir      = ~w_stall;
    dbubble    = w_stall;
    mc_busy    = w_mc_busy;
    stall_cnt  = r_stall_cnt;
  end

  always_comb begin
    w_mc_cnt_nxt    = r_mc_cnt;
    w_mc_rn_nxt     = r_mc_rn;
    w_stall_cnt_nxt = r_stall_cnt;
    if (d_valid && !w_stall && d_mc) begin
      w_mc_cnt_nxt = McLatV;
      w_mc_rn_nxt  = d_rn;
    end else if (w_mc_busy) begin
      w_mc_cnt_nxt = r_mc_cnt - MCW'(1);
    end
    if (w_stall && (r_stall_cnt != '1)) begin
      w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mc_cnt    <= '0;
      r_mc_rn     <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_mc_cnt    <= w_mc_cnt_nxt;
      r_mc_rn     <= w_mc_rn_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_sb.sv
// Directed bench for pipe_hazard_sb; stimulus pushes expectations, a negedge monitor checks them.
`timescale 1ns/1ps

module tb_pipe_hazard_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;
  localparam int unsigned CW   = 4;

  localparam logic [7:0] MFa = 8'h01, MFb = 8'h02, MDa = 8'h04, MDb = 8'h08;
  localparam logic [7:0] MWp = 8'h10, MBub = 8'h20, MBusy = 8'h40, MCnt = 8'h80;
  localparam logic [7:0] MStall = 8'hF0, MAll = 8'hFF;

  localparam logic [31:0] QA = 32'hAAAA_0001, QB = 32'hBBBB_0002;

  logic clock = 1'b0;
  logic resetn;
  logic d_valid, use_rs, use_rt, d_wreg, d_mc;
  logic [RAW-1:0] rs, rt, d_rn, ern, mrn;
  logic ewreg, em2reg, mwreg, mm2reg;
  logic [XLEN-1:0] qa, qb, ealu, malu, mmo;
`ifdef PIPE_WB_FWD_EN
  logic wwreg;
  logic [RAW-1:0] wrn;
  logic [XLEN-1:0] wdi;
`endif
  logic [2:0] fwda, fwdb;
  logic [XLEN-1:0] da, db;
  logic wpcir, dbubble, mc_busy;
  logic [CW-1:0] stall_cnt;

  always #5 clock = ~clock;

  pipe_hazard_sb #(.XLEN(XLEN), .RAW(RAW), .MC_LAT(4), .CNT_W(CW)) dut (
    .clock(clock), .resetn(resetn), .d_valid(d_valid), .rs(rs), .rt(rt),
    .use_rs(use_rs), .use_rt(use_rt), .d_wreg(d_wreg), .d_rn(d_rn), .d_mc(d_mc),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
    .qa(qa), .qb(qb), .ealu(ealu), .malu(malu), .mmo(mmo),
`ifdef PIPE_WB_FWD_EN
    .wwreg(wwreg), .wrn(wrn), .wdi(wdi),
`endif
    .fwda(fwda), .fwdb(fwdb), .da(da), .db(db), .wpcir(wpcir), .dbubble(dbubble),
    .mc_busy(mc_busy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    string      name;
    logic [7:0] mask;
    logic [2:0] fa, fb;
    logic [31:0] xa, xb;
    logic       wp, bub, busy;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event ev_chk;

  task automatic push(input string name, input logic [7:0] mask, input logic [2:0] fa,
                      input logic [2:0] fb, input logic [31:0] xa, input logic [31:0] xb,
                      input logic wp, input logic bub, input logic busy, input logic [3:0] cnt);
    exp_t e;
    e.name = name; e.mask = mask; e.fa = fa; e.fb = fb; e.xa = xa; e.xb = xb;
    e.wp = wp; e.bub = bub; e.busy = busy; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic cmp(input string name, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, fld, act, exp);
    end
  endtask

  // Monitor: drains expectations at every negedge (or on demand for async checks).
  initial begin
    exp_t e;
    forever begin
      @(negedge clock or ev_chk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.mask[0]) cmp(e.name, "fwda", 32'(fwda), 32'(e.fa));
        if (e.mask[1]) cmp(e.name, "fwdb", 32'(fwdb), 32'(e.fb));
        if (e.mask[2]) cmp(e.name, "da", da, e.xa);
        if (e.mask[3]) cmp(e.name, "db", db, e.xb);
        if (e.mask[4]) cmp(e.name, "wpcir", 32'(wpcir), 32'(e.wp));
        if (e.mask[5]) cmp(e.name, "dbubble", 32'(dbubble), 32'(e.bub));
        if (e.mask[6]) cmp(e.name, "mc_busy", 32'(mc_busy), 32'(e.busy));
        if (e.mask[7]) cmp(e.name, "stall_cnt", 32'(stall_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    d_valid = 0; use_rs = 0; use_rt = 0; d_wreg = 0; d_mc = 0;
    rs = '0; rt = '0; d_rn = '0; ern = '0; mrn = '0;
    ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
`ifdef PIPE_WB_FWD_EN
    wwreg = 0; wrn = '0;
`endif
  endtask

  initial begin
    qa = QA; qb = QB; ealu = 32'h11; malu = 32'h22; mmo = 32'hDEAD;
`ifdef PIPE_WB_FWD_EN
    wdi = 32'h4444;
`endif
    resetn = 0;
    clr();
    tick();
    push("reset", MAll, 3'd0, 3'd0, QA, QB, 1, 0, 0, 4'd0);
    tick();
    resetn = 1;

    // EXE beats MEM, then MEM when EXE drops
    tick();
    d_valid = 1; ewreg = 1; mwreg = 1; ern = 5'd7; mrn = 5'd7; rs = 5'd7; rt = 5'd7; use_rs = 1;
    push("fwd_exe", MAll, 3'd1, 3'd1, 32'h11, 32'h11, 1, 0, 0, 4'd0);
    tick();
    ewreg = 0;
    push("fwd_mem", MAll, 3'd2, 3'd2, 32'h22, 32'h22, 1, 0, 0, 4'd0);

    // MEM load data on rt; register 0 on rs never forwards
    tick(); clr();
    d_valid = 1; mwreg = 1; mm2reg = 1; mrn = 5'd3; rt = 5'd3; use_rt = 1;
    ewreg = 1; ern = 5'd0; rs = 5'd0; use_rs = 1;
    push("fwd_mmo_r0", MAll, 3'd0, 3'd3, QA, 32'hDEAD, 1, 0, 0, 4'd0);
    tick(); clr();
    d_valid = 1; ewreg = 1; em2reg = 1; ern = 5'd0; rs = 5'd0; use_rs = 1;
    push("ld_r0_nostall", MAll, 3'd0, 3'd0, QA, QB, 1, 0, 0, 4'd0);

    // Load-use stall, counted per cycle held
    tick(); clr();
    d_valid = 1; ewreg = 1; em2reg = 1; ern = 5'd5; rs = 5'd5; use_rs = 1;
    push("ld_use0", MAll, 3'd0, 3'd0, QA, QB, 0, 1, 0, 4'd0);
    tick(); push("ld_use1", MStall, 0, 0, 0, 0, 0, 1, 0, 4'd1);
    tick(); push("ld_use2", MStall, 0, 0, 0, 0, 0, 1, 0, 4'd2);
    tick(); use_rs = 0; use_rt = 1; rt = 5'd5;
    push("ld_use_rt", MStall, 0, 0, 0, 0, 0, 1, 0, 4'd3);
    tick(); d_valid = 0;
    push("ld_use_invalid", MStall, 0, 0, 0, 0, 1, 0, 0, 4'd4);
    tick(); clr();
    push("idle_cnt", MStall, 0, 0, 0, 0, 1, 0, 0, 4'd4);

    // MC issue then RAW dependant: exactly 4 stall cycles
    tick(); clr();
    d_valid = 1; d_mc = 1; d_wreg = 1; d_rn = 5'd9;
    push("mc_issue", MStall, 0, 0, 0, 0, 1, 0, 0, 4'd4);
    tick(); clr();
    d_valid = 1; rs = 5'd9; use_rs = 1; d_wreg = 1; d_rn = 5'd10;
    push("mc_raw0", MStall, 0, 0, 0, 0, 0, 1, 1, 4'd4);
    for (int k = 1; k < 4; k++) begin
      tick();
      push("mc_raw", MStall, 0, 0, 0, 0, 0, 1, 1, 4'(4 + k));
    end
    tick();
    push("mc_raw_release", MStall, 0, 0, 0, 0, 1, 0, 0, 4'd8);

    // Second MC instruction stalls structurally until mc_cnt==0, then issues
    tick(); clr();
    d_valid = 1; d_mc = 1; d_wreg = 1; d_rn = 5'd9;
    push("mc_issue2", MStall, 0, 0, 0, 0, 1, 0, 0, 4'd8);
    tick(); clr();
    d_valid = 1; d_mc = 1; d_wreg = 1; d_rn = 5'd12;
    push("mc_struct0", MStall, 0, 0, 0, 0, 0, 1, 1, 4'd8);
    for (int k = 1; k < 4; k++) begin
      tick();
      push("mc_struct", MStall, 0, 0, 0, 0, 0, 1, 1, 4'(8 + k));
    end
    tick();
    push("mc_struct_issue", MStall, 0, 0, 0, 0, 1, 0, 0, 4'd12);

    // WAW against the in-flight MC destination, then async reset at mc_cnt==2
    tick(); clr();
    d_valid = 1; d_wreg = 1; d_rn = 5'd12;
    push("mc_waw4", MStall, 0, 0, 0, 0, 0, 1, 1, 4'd12);
    tick(); push("mc_waw3", MStall, 0, 0, 0, 0, 0, 1, 1, 4'd13);
    tick(); push("mc_waw2", MStall, 0, 0, 0, 0, 0, 1, 1, 4'd14);
    @(negedge clock);
    #1;
    resetn = 0;
    #1;
    push("async_reset", MStall, 0, 0, 0, 0, 1, 0, 0, 4'd0);
    -> ev_chk;
    tick();
    resetn = 1;
    tick();
    push("post_reset", MStall, 0, 0, 0, 0, 1, 0, 0, 4'd0);

    // Saturation of a 4-bit counter over 20 stall cycles
    tick(); clr();
    d_valid = 1; ewreg = 1; em2reg = 1; ern = 5'd6; rt = 5'd6; use_rt = 1;
    for (int i = 0; i < 20; i++) begin
      push("sat", MStall, 0, 0, 0, 0, 0, 1, 0, (i < 15) ? 4'(i) : 4'd15);
      tick();
    end
    clr();
    push("sat_hold", MStall, 0, 0, 0, 0, 1, 0, 0, 4'd15);

`ifdef PIPE_WB_FWD_EN
    tick(); clr();
    d_valid = 1; wwreg = 1; wrn = 5'd4; rs = 5'd4; use_rs = 1;
    push("fwd_wb", MFa | MDa, 3'd4, 0, 32'h4444, 0, 0, 0, 0, 0);
    tick();
    mwreg = 1; mrn = 5'd4;
    push("fwd_mem_over_wb", MFa | MDa, 3'd2, 0, 32'h22, 0, 0, 0, 0, 0);
    tick(); clr();
    wwreg = 1; wrn = 5'd0; rs = 5'd0;
    push("fwd_wb_r0", MFa | MDa, 3'd0, 0, QA, 0, 0, 0, 0, 0);
`endif

    tick(); clr();
    tick();
    tick();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
